// File: rtl/alsu_arbiter_pkg.sv
// rtl/alsu_arbiter_pkg.sv - ALSU opcodes, command field layout and legality check
package alsu_arbiter_pkg;

    localparam logic [2:0] OP_AND       = 3'd0;
    localparam logic [2:0] OP_XOR       = 3'd1;
    localparam logic [2:0] OP_ADD       = 3'd2;
    localparam logic [2:0] OP_MULT      = 3'd3;
    localparam logic [2:0] OP_SHIFT     = 3'd4;
    localparam logic [2:0] OP_ROTATE    = 3'd5;
    localparam logic [2:0] OP_INVALID_6 = 3'd6;
    localparam logic [2:0] OP_INVALID_7 = 3'd7;

    // Command word, LSB upwards: pass_B, pass_A, red_op_B, red_op_A, sh_left, SI, cin, opcode, B, A
    localparam int OFF_PASS_B  = 0;
    localparam int OFF_PASS_A  = 1;
    localparam int OFF_RED_B   = 2;
    localparam int OFF_RED_A   = 3;
    localparam int OFF_SH_LEFT = 4;
    localparam int OFF_SI      = 5;
    localparam int OFF_CIN     = 6;
    localparam int OFF_OPCODE  = 7;
    localparam int OFF_B       = 10;

    function automatic int off_a(input int bits);
        return OFF_B + bits;
    endfunction

    function automatic int cmd_w(input int bits);
        return 2 * bits + 10;
    endfunction

    // Same cases the ALSU itself treats as invalid; reductions only make sense for AND/XOR.
    function automatic logic cmd_is_err(input logic [2:0] op, input logic red_a, input logic red_b);
        return (op == OP_INVALID_6) || (op == OP_INVALID_7) ||
               ((red_a | red_b) && (op != OP_AND) && (op != OP_XOR));
    endfunction

endpackage

// File: rtl/alsu_arbiter_rr_arbiter.sv
// rtl/alsu_arbiter_rr_arbiter.sv - combinational round-robin grant starting after last_grant
module rr_arbiter
    import alsu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = (int'(i_last_grant) + off) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/alsu_arbiter.sv
// rtl/alsu_arbiter.sv - shares one ALSU among NUM_REQ requesters with an ID/error tag pipeline
module alsu_arbiter
    import alsu_arbiter_pkg::*;
#(
    parameter int BITS     = 3,
    parameter int NUM_REQ  = 4,
    parameter int ALSU_LAT = 2,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              arb_en,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*(2*BITS+10)-1:0]    req_cmd,
    output logic                              rsp_valid,
    output logic [ID_W-1:0]                   rsp_id,
    output logic [2*BITS-1:0]                 rsp_data,
    output logic                              rsp_err,
    output logic                              busy,
    output logic [BITS-1:0]                   alsu_A,
    output logic [BITS-1:0]                   alsu_B,
    output logic [2:0]                        alsu_opcode,
    output logic                              alsu_cin,
    output logic                              alsu_SI,
    output logic                              alsu_sh_left,
    output logic                              alsu_red_op_A,
    output logic                              alsu_red_op_B,
    output logic                              alsu_pass_A,
    output logic                              alsu_pass_B,
    input  logic [2*BITS-1:0]                 alsu_out
);

    localparam int CMD_W = cmd_w(BITS);
    // Issue stage plus ALSU_LAT stages inside the ALSU before alsu_out matches.
    localparam int TAG_N = ALSU_LAT + 1;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_accept;
    logic [CMD_W-1:0]   w_cmd;
    logic               w_err;

    logic [CMD_W-1:0]   r_cmd;
    logic [ID_W-1:0]    r_last_grant;
    logic [TAG_N-1:0]   r_tag_valid;
    logic [TAG_N-1:0]   r_tag_err;
    logic [ID_W-1:0]    r_tag_id [TAG_N];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    assign req_ready = (rstn && arb_en) ? w_grant : '0;
    assign w_accept  = |(req_valid & req_ready);
    assign w_cmd     = req_cmd[int'(w_grant_idx)*CMD_W +: CMD_W];
    assign w_err     = cmd_is_err(w_cmd[OFF_OPCODE +: 3], w_cmd[OFF_RED_A], w_cmd[OFF_RED_B]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cmd        <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_tag_valid  <= '0;
            r_tag_err    <= '0;
            for (int s = 0; s < TAG_N; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_cmd        <= w_cmd;
                r_last_grant <= w_grant_idx;
            end
            r_tag_valid <= {r_tag_valid[TAG_N-2:0], w_accept};
            r_tag_err   <= {r_tag_err[TAG_N-2:0], w_accept & w_err};
            r_tag_id[0] <= w_grant_idx;
            for (int s = 1; s < TAG_N; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    assign alsu_A        = r_cmd[off_a(BITS) +: BITS];
    assign alsu_B        = r_cmd[OFF_B +: BITS];
    assign alsu_opcode   = r_cmd[OFF_OPCODE +: 3];
    assign alsu_cin      = r_cmd[OFF_CIN];
    assign alsu_SI       = r_cmd[OFF_SI];
    assign alsu_sh_left  = r_cmd[OFF_SH_LEFT];
    assign alsu_red_op_A = r_cmd[OFF_RED_A];
    assign alsu_red_op_B = r_cmd[OFF_RED_B];
    assign alsu_pass_A   = r_cmd[OFF_PASS_A];
    assign alsu_pass_B   = r_cmd[OFF_PASS_B];

    assign rsp_valid = r_tag_valid[TAG_N-1];
    assign rsp_id    = r_tag_id[TAG_N-1];
    assign rsp_err   = r_tag_err[TAG_N-1];
    assign rsp_data  = alsu_out;
    assign busy      = |r_tag_valid;

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb/tb_alsu_arbiter.sv - directed self-checking bench for alsu_arbiter
module tb_alsu_arbiter;

    logic        clk;
    logic        rstn;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_cmd;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [5:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_SI, alsu_sh_left, alsu_red_op_A, alsu_red_op_B, alsu_pass_A, alsu_pass_B;
    logic [5:0]  alsu_out;

    int n_cmp = 0;
    int n_bad = 0;

    alsu_arbiter #(.BITS(3), .NUM_REQ(4), .ALSU_LAT(2), .ID_W(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .arb_en        (arb_en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .rsp_valid     (rsp_valid),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .alsu_A        (alsu_A),
        .alsu_B        (alsu_B),
        .alsu_opcode   (alsu_opcode),
        .alsu_cin      (alsu_cin),
        .alsu_SI       (alsu_SI),
        .alsu_sh_left  (alsu_sh_left),
        .alsu_red_op_A (alsu_red_op_A),
        .alsu_red_op_B (alsu_red_op_B),
        .alsu_pass_A   (alsu_pass_A),
        .alsu_pass_B   (alsu_pass_B),
        .alsu_out      (alsu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-stage ALSU stand-in: inputs registered, then output registered.
    logic [2:0] m_a, m_b, m_op;
    logic       m_cin;
    always @(posedge clk) begin
        m_a   <= alsu_A;
        m_b   <= alsu_B;
        m_op  <= alsu_opcode;
        m_cin <= alsu_cin;
        if (m_op == 3'd0)      alsu_out <= {3'b000, m_a & m_b};
        else if (m_op == 3'd1) alsu_out <= {3'b000, m_a ^ m_b};
        else if (m_op == 3'd2) alsu_out <= {3'b000, m_a} + {3'b000, m_b} + {5'b00000, m_cin};
        else                   alsu_out <= 6'd0;
    end

    function automatic logic [15:0] mk_cmd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                                           input logic cin, input logic red_a, input logic red_b);
        return {a, b, op, cin, 1'b0, 1'b0, red_a, red_b, 1'b0, 1'b0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        arb_en    = 1'b1;
        req_valid = 4'b1111;
        req_cmd   = {4{16'hFFFF}};
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if ({alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_SI, alsu_sh_left, alsu_red_op_A,
             alsu_red_op_B, alsu_pass_A, alsu_pass_B} !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_alsu got %h want 0000", {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_SI,
                     alsu_sh_left, alsu_red_op_A, alsu_red_op_B, alsu_pass_A, alsu_pass_B});
        end
        req_valid = 4'b0000;
        rstn      = 1'b1;
    endtask

    task automatic test_single_add();
        req_cmd[32 +: 16] = mk_cmd(3'd5, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL add_ready got %b want 0100", req_ready); end
        cyc();
        req_valid = 4'b0000;
        n_cmp++; if (alsu_opcode !== 3'd2) begin n_bad++; $display("FAIL add_opcode got %0d want 2", alsu_opcode); end
        n_cmp++; if (alsu_A !== 3'd5) begin n_bad++; $display("FAIL add_A got %0d want 5", alsu_A); end
        n_cmp++; if (alsu_B !== 3'd1) begin n_bad++; $display("FAIL add_B got %0d want 1", alsu_B); end
        n_cmp++; if (alsu_cin !== 1'b1) begin n_bad++; $display("FAIL add_cin got %b want 1", alsu_cin); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_busy got %b want 1", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early0 got %b want 0", rsp_valid); end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early1 got %b want 0", rsp_valid); end
        n_cmp++; if (alsu_opcode !== 3'd2) begin n_bad++; $display("FAIL add_hold got %0d want 2", alsu_opcode); end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_rsp_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_bad++; $display("FAIL add_rsp_id got %0d want 2", rsp_id); end
        n_cmp++; if (rsp_data !== 6'd7) begin n_bad++; $display("FAIL add_rsp_data got %0d want 7", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL add_rsp_err got %b want 0", rsp_err); end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_rsp_once got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_busy_end got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        rstn = 1'b0;
        cyc();
        rstn    = 1'b1;
        req_cmd = {4{mk_cmd(3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0)}};
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) req_valid = 4'b0000;
            #1;
            if (i < 8) begin
                exp_rdy = 4'b0001 << (i % 4);
                n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", i, req_ready, exp_rdy); end
            end
            cyc();
            n_cmp++; if (rsp_valid !== (i >= 2)) begin n_bad++; $display("FAIL rr_rsp_valid[%0d] got %b want %b", i, rsp_valid, (i >= 2)); end
            if (i >= 2) begin
                exp_id = 2'((i - 2) % 4);
                n_cmp++; if (rsp_id !== exp_id) begin n_bad++; $display("FAIL rr_rsp_id[%0d] got %0d want %0d", i, rsp_id, exp_id); end
            end
        end
        cyc();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_tail got %b want 0", rsp_valid); end
    endtask

    task automatic test_errors();
        int         ids  [3] = '{1, 3, 0};
        logic       errs [3] = '{1'b1, 1'b1, 1'b0};
        req_cmd[16 +: 16] = mk_cmd(3'd1, 3'd2, 3'd7, 1'b0, 1'b0, 1'b0);
        req_cmd[48 +: 16] = mk_cmd(3'd1, 3'd2, 3'd2, 1'b0, 1'b1, 1'b0);
        req_cmd[0  +: 16] = mk_cmd(3'd1, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            req_valid = (i < 3) ? (4'b0001 << ids[i]) : 4'b0000;
            cyc();
            if (i >= 2) begin
                n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL err_valid[%0d] got %b want 1", i, rsp_valid); end
                n_cmp++; if (rsp_id !== 2'(ids[i-2])) begin n_bad++; $display("FAIL err_id[%0d] got %0d want %0d", i, rsp_id, ids[i-2]); end
                n_cmp++; if (rsp_err !== errs[i-2]) begin n_bad++; $display("FAIL err_flag[%0d] got %b want %b", i, rsp_err, errs[i-2]); end
            end
        end
    endtask

    task automatic test_drain();
        logic [3:0] exp_rdy [6] = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        req_cmd   = {4{mk_cmd(3'd2, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0)}};
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            arb_en = (i < 2);
            #1;
            n_cmp++; if (req_ready !== exp_rdy[i]) begin n_bad++; $display("FAIL drain_ready[%0d] got %b want %b", i, req_ready, exp_rdy[i]); end
            cyc();
            n_cmp++; if (rsp_valid !== (i == 2 || i == 3)) begin n_bad++; $display("FAIL drain_valid[%0d] got %b want %b", i, rsp_valid, (i == 2 || i == 3)); end
            if (i == 2 || i == 3) begin
                n_cmp++; if (rsp_id !== ((i == 2) ? 2'd1 : 2'd2)) begin n_bad++; $display("FAIL drain_id[%0d] got %0d want %0d", i, rsp_id, (i == 2) ? 1 : 2); end
            end
            n_cmp++; if (busy !== (i < 4)) begin n_bad++; $display("FAIL drain_busy[%0d] got %b want %b", i, busy, (i < 4)); end
        end
        arb_en = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL drain_resume got %b want 1000", req_ready); end
        req_valid = 4'b0000;
        cyc();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1111;
        cyc();
        cyc();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre got %b want 1", busy); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_rst got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_ready_rst got %b want 0000", req_ready); end
        cyc();
        rstn = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
        req_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp[%0d] got %b want 0", i, rsp_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_errors();
        test_drain();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
